// File: rtl/timing_loop_nco.sv
// Gardner timing loop: PI loop filter on TED errors steering a modulo-2^PhaseLengthBits NCO that raises trigger.
// Latency: error accepted at edge T updates control/control_valid at T+1; trigger follows control combinationally from registers.
// Backpressure: in_ready drops for one cycle after each accepted error (max one error per 2 cycles); define TIMING_LOOP_INTEGRATOR_EN for the PI filter, else P only.
module timing_loop_nco #(
  parameter int SamplesPerSymbol  = 4,
  parameter int ErrorLengthBits   = 25,
  parameter int PhaseLengthBits   = 16,
  parameter int ControlLengthBits = 16,
  parameter int KpShift           = 10,
  parameter int KiShift           = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [ErrorLengthBits-1:0]   in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                sample_valid,
  output logic                                trigger,
  output logic signed [ControlLengthBits-1:0] control,
  output logic                                control_valid
);

  localparam int NominalStep = (1 << PhaseLengthBits) / SamplesPerSymbol;
  localparam int SatLimit    = NominalStep / 4;
  // Wide enough that p + integrator (or integrator + i) can never wrap before clamping.
  localparam int SumBits     = ((ErrorLengthBits > ControlLengthBits) ? ErrorLengthBits : ControlLengthBits) + 2;

  localparam logic signed [SumBits-1:0] SatHi = SumBits'(SatLimit);
  localparam logic signed [SumBits-1:0] SatLo = -SumBits'(SatLimit);

  typedef enum logic {READY, BUSY} state_t;

  state_t state;
  state_t state_next;
  logic   accept;

  logic signed [ErrorLengthBits-1:0]   p_reg;
  logic signed [ControlLengthBits-1:0] integ_next;
  logic signed [ControlLengthBits-1:0] ctrl_next;

  logic [PhaseLengthBits-1:0]        phase;
  logic signed [PhaseLengthBits:0]   step;
  logic [PhaseLengthBits:0]          phase_sum;

  function automatic logic signed [SumBits-1:0] sat(input logic signed [SumBits-1:0] x);
    if (x > SatHi) begin
      return SatHi;
    end else if (x < SatLo) begin
      return SatLo;
    end else begin
      return x;
    end
  endfunction

  // Loop-filter state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= READY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode: READY takes one error, BUSY spends one cycle updating.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      READY: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        state_next = READY;
      end
      default: begin
        state_next = READY;
      end
    endcase
  end

  // Proportional term captured at the handshake (arithmetic shift floors toward -inf).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_reg <= '0;
    end else if (accept) begin
      p_reg <= in >>> KpShift;
    end
  end

`ifdef TIMING_LOOP_INTEGRATOR_EN
  logic signed [ErrorLengthBits-1:0]   i_reg;
  logic signed [ControlLengthBits-1:0] integrator;

  // Integral increment captured at the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_reg <= '0;
    end else if (accept) begin
      i_reg <= in >>> KiShift;
    end
  end

  // Clamped integrator sum; clamping the stored value is what prevents windup.
  always_comb begin
    integ_next = ControlLengthBits'(sat(SumBits'(integrator) + SumBits'(i_reg)));
  end

  // Integrator register, updated only in BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      integrator <= '0;
    end else if (state == BUSY) begin
      integrator <= integ_next;
    end
  end
`else
  // Proportional-only build: the integrator contributes nothing.
  always_comb begin
    integ_next = '0;
  end
`endif

  // Filter output: proportional term plus the freshly updated integrator, clamped.
  always_comb begin
    ctrl_next = ControlLengthBits'(sat(SumBits'(p_reg) + SumBits'(integ_next)));
  end

  // Control word and its one-cycle update strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      control       <= '0;
      control_valid <= 1'b0;
    end else begin
      control_valid <= (state == BUSY);
      if (state == BUSY) begin
        control <= ctrl_next;
      end
    end
  end

  // Step and next-phase sum come only from registers, so trigger has no input-to-output path.
  always_comb begin
    step      = (PhaseLengthBits+1)'(NominalStep) + (PhaseLengthBits+1)'(control);
    phase_sum = {1'b0, phase} + $unsigned(step);
    trigger   = phase_sum[PhaseLengthBits];
  end

  // Phase accumulator advances once per input sample and wraps modulo 2^PhaseLengthBits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (sample_valid) begin
      phase <= phase_sum[PhaseLengthBits-1:0];
    end
  end

endmodule

// File: tb/tb_timing_loop_nco.sv
module tb_timing_loop_nco;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [24:0] err;
  logic               in_valid;
  logic               in_ready;
  logic               sample_valid;
  logic               trigger;
  logic signed [15:0] control;
  logic               control_valid;

  int total  = 0;
  int passed = 0;

  int exp_phase = 0;
  int exp_ctrl  = 0;
  int exp_integ = 0;

  timing_loop_nco dut (
    .clk           (clk),
    .rst           (rst),
    .in            (err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sample_valid  (sample_valid),
    .trigger       (trigger),
    .control       (control),
    .control_valid (control_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  function automatic int clamp(input int x);
    if (x > 4096) return 4096;
    if (x < -4096) return -4096;
    return x;
  endfunction

  function automatic logic exp_trig();
    return (exp_phase + 16384 + exp_ctrl) >= 65536;
  endfunction

  task automatic advance();
    exp_phase = (exp_phase + 16384 + exp_ctrl) % 65536;
  endtask

  task automatic model_accept(input int e);
    int p;
    int i;
    p = e >>> 10;
    i = e >>> 16;
`ifdef TIMING_LOOP_INTEGRATOR_EN
    exp_integ = clamp(exp_integ + i);
    exp_ctrl  = clamp(p + exp_integ);
`else
    exp_integ = 0 * i;
    exp_ctrl  = clamp(p);
`endif
  endtask

  // Full handshake with sample_valid low; checks the 2-cycle timing and the resulting control.
  task automatic send(input int e);
    chk("send_ready_before", in_ready, 1);
    err = 25'(e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    model_accept(e);
    chk("send_ready_busy", in_ready, 0);
    chk("send_cv_busy", control_valid, 0);
    tick();
    chk("send_cv_pulse", control_valid, 1);
    chk("send_control", control, exp_ctrl);
    chk("send_ready_back", in_ready, 1);
    tick();
    chk("send_cv_fall", control_valid, 0);
  endtask

  initial begin
    int last;
    int ntrig;
    int first;

    rst = 1'b0;
    err = '0;
    in_valid = 1'b0;
    sample_valid = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_trigger", trigger, 0);
    chk("rst_control", control, 0);
    chk("rst_cv", control_valid, 0);
    chk("rst_phase", dut.phase, 0);

    // Free-running NCO at nominal step.
    tick();
    rst = 1'b1;
    sample_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("nom_trigger", trigger, ((k % 4) == 3) ? 1 : 0);
      chk("nom_trigger_model", trigger, exp_trig());
      tick();
      advance();
      chk("nom_phase", dut.phase, ((k + 1) % 4) * 16384);
      chk("nom_phase_model", dut.phase, exp_phase);
      chk("nom_cv", control_valid, 0);
      chk("nom_control", control, 0);
    end
    sample_valid = 1'b0;
    tick();
    tick();
    chk("hold_phase", dut.phase, exp_phase);
    chk("hold_trigger", trigger, 0);

    // Single handshakes with in = 65536.
    send(65536);
`ifdef TIMING_LOOP_INTEGRATOR_EN
    chk("hs1_const", control, 65);
`else
    chk("hs1_const", control, 64);
`endif
    send(65536);
`ifdef TIMING_LOOP_INTEGRATOR_EN
    chk("hs2_const", control, 66);
`else
    chk("hs2_const", control, 64);
`endif

    // in_valid held high: one acceptance every two cycles.
    err = 25'(65536);
    in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if ((k % 2) == 1) model_accept(65536);
      chk("held_ready", in_ready, ((k % 2) == 0) ? 1 : 0);
      chk("held_cv", control_valid, ((k % 2) == 0) ? 1 : 0);
      if ((k % 2) == 0) chk("held_control", control, exp_ctrl);
    end
    in_valid = 1'b0;
`ifdef TIMING_LOOP_INTEGRATOR_EN
    chk("held_const", control, 69);
`else
    chk("held_const", control, 64);
`endif
    tick();

    // Positive saturation, then sustained negative errors.
    send(4190209);
`ifdef TIMING_LOOP_INTEGRATOR_EN
    chk("satp_const", control, 4096);
`else
    chk("satp_const", control, 4092);
`endif
    for (int k = 0; k < 100; k++) begin
      send(-4194304);
`ifdef TIMING_LOOP_INTEGRATOR_EN
      chk("integ_floor", (dut.integrator >= -16'sd4096) ? 1 : 0, 1);
`endif
    end
    chk("satn_const", control, -4096);
`ifdef TIMING_LOOP_INTEGRATOR_EN
    chk("satn_integ", dut.integrator, -4096);
`endif

    // Reset asserted in BUSY with samples running.
    sample_valid = 1'b1;
    err = 25'(65536);
    in_valid = 1'b1;
    tick();
    chk("mid_busy_ready", in_ready, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cv", control_valid, 0);
    chk("mid_rst_control", control, 0);
    chk("mid_rst_trigger", trigger, 0);
    chk("mid_rst_phase", dut.phase, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_held_ready", in_ready, 1);
      chk("rst_held_cv", control_valid, 0);
      chk("rst_held_control", control, 0);
      chk("rst_held_trigger", trigger, 0);
      chk("rst_held_phase", dut.phase, 0);
    end
    in_valid = 1'b0;
    sample_valid = 1'b0;
    rst = 1'b1;
    exp_phase = 0;
    exp_ctrl = 0;
    exp_integ = 0;
    tick();
    chk("post_rst_control", control, 0);
    chk("post_rst_cv", control_valid, 0);

    // Maximum control: step 20480, 5 wraps per 16 samples.
    send(4194304);
    chk("fast_const", control, 4096);
    sample_valid = 1'b1;
    last = -1;
    ntrig = 0;
    first = -1;
    for (int n = 0; n < 80; n++) begin
      chk("fast_trigger_model", trigger, exp_trig());
      if (trigger === 1'b1) begin
        ntrig++;
        if (first < 0) first = n;
        if (last >= 0) chk("fast_interval", ((n - last) == 3 || (n - last) == 4) ? 1 : 0, 1);
        last = n;
      end
      tick();
      advance();
      chk("fast_phase", dut.phase, exp_phase);
    end
    sample_valid = 1'b0;
    chk("fast_first_trigger", first, 3);
    chk("fast_trigger_count", ntrig, 25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
